// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one radix-4 Booth multiplier among NREQ lanes,
// with a two-stage operand/result pipeline tagged by lane ID.

module multiply #(
  parameter int N1 = 16,
  parameter int N2 = 16
) (
  input  logic [N1-1:0]    in1,
  input  logic [N2-1:0]    in2,
  output logic [N1+N2-2:0] ou
);
  localparam int W = N1 + N2 - 1;

  logic signed [W-1:0] a_ext;
  logic signed [W-1:0] pp;
  logic signed [W-1:0] acc;
  logic [N2:0]         bext;
  logic [2:0]          trip;

  // Accumulating in W bits keeps only the low N1+N2-1 product bits.
  always_comb begin
    a_ext = W'($signed(in1));
    bext  = {in2, 1'b0};
    acc   = '0;
    pp    = '0;
    trip  = '0;
    for (int unsigned j = 0; j < N2 / 2; j++) begin
      trip = bext[2*j +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * j));
    end
    ou = acc;
  end
endmodule

module mul_share_arbiter #(
  parameter int N1   = 16,
  parameter int N2   = 16,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*N1-1:0]    a_flat,
  input  logic [NREQ*N2-1:0]    b_flat,
  input  logic                  hold,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [N1+N2-2:0]      res,
  output logic                  busy
);
  localparam int RW = N1 + N2 - 1;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           v1_q, v1_d;
  logic [IDW-1:0] id1_q, id1_d;
  logic [N1-1:0]  a1_q, a1_d;
  logic [N2-1:0]  b1_q, b1_d;
  logic           res_valid_q;
  logic [IDW-1:0] res_id_q;
  logic [RW-1:0]  res_q;
  logic [RW-1:0]  prod;

  logic [IDW-1:0] g;
  logic           any_gnt;
  int unsigned    idx;

  // Scan from ptr upward with wrap; rst_n gates grants so nothing leaks out during reset.
  always_comb begin
    gnt     = '0;
    g       = '0;
    any_gnt = 1'b0;
    idx     = 0;
    if (rst_n && !hold) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr_q) + k) % NREQ;
        if (!any_gnt && req[idx]) begin
          any_gnt  = 1'b1;
          g        = IDW'(idx);
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    v1_d  = any_gnt;
    id1_d = id1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    if (any_gnt) begin
      ptr_d = IDW'((32'(g) + 1) % NREQ);
      id1_d = g;
      a1_d  = a_flat[32'(g)*N1 +: N1];
      b1_d  = b_flat[32'(g)*N2 +: N2];
    end
  end

  multiply #(.N1(N1), .N2(N2)) u_mul (
    .in1 (a1_q),
    .in2 (b1_q),
    .ou  (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      v1_q        <= 1'b0;
      id1_q       <= '0;
      a1_q        <= '0;
      b1_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      v1_q        <= v1_d;
      id1_q       <= id1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      res_valid_q <= v1_q;
      res_id_q    <= id1_q;
      res_q       <= prod;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res       = res_q;
  assign busy      = v1_q | res_valid_q;
endmodule
